// File: rtl/mycpu_pkg.sv
// Shared types and constants for the memory-mapped IO block.
package mycpu_pkg;

    // Register index taken from addr_in[1:0]
    typedef enum logic [1:0] {
        IO_OUT  = 2'd0,
        IO_IN   = 2'd1,
        IO_STAT = 2'd2,
        IO_TMR  = 2'd3
    } io_reg_t;

    // Interval timer mode
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } io_tmr_state_t;

    // STATUS bit positions
    localparam int STAT_CHG  = 0;
    localparam int STAT_TEXP = 1;
    localparam int STAT_W    = 2;

    localparam int IO_DW = 16;

endpackage : mycpu_pkg

// File: rtl/io_sync2.sv
// Two-flop synchronizer for asynchronous input pins.
module io_sync2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; first stage may go metastable, second settles it
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so both stages sample pre-edge values and form a true two-flop chain.
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule : io_sync2

// File: rtl/io_unit.sv
// Memory-mapped IO block: output port, synchronized input port,
// sticky status with write-one-to-clear, and a reloading interval timer.
module io_unit
    import mycpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iom_in,
    input  logic             wen_in,
    input  logic [IO_DW-1:0] addr_in,
    input  logic [IO_DW-1:0] data_in,
    output logic [IO_DW-1:0] data_out,
    input  logic [IO_DW-1:0] port_in,
    output logic [IO_DW-1:0] port_out,
    output logic             irq_out
);

    // Upper address bits alias onto the four registers
    logic unused_addr;
    assign unused_addr = ^addr_in[IO_DW-1:2];

    io_reg_t       reg_sel;
    logic          wr_en;
    logic [IO_DW-1:0] port_sync;

    logic [IO_DW-1:0] port_out_q, port_out_d;
    logic [IO_DW-1:0] prev_q,     prev_d;
    logic [STAT_W-1:0] stat_q,    stat_d;
    logic [IO_DW-1:0] reload_q,   reload_d;
    logic [IO_DW-1:0] count_q,    count_d;
    io_tmr_state_t    state_q,    state_d;
    logic             irq_q,      irq_d;

    logic             chg_set;
    logic             texp_set;
    logic [STAT_W-1:0] stat_set;
    logic [STAT_W-1:0] stat_clr;

    assign reg_sel = io_reg_t'(addr_in[1:0]);
    assign wr_en   = iom_in & ~wen_in;

    io_sync2 #(.WIDTH(IO_DW)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (port_in),
        .q_out (port_sync)
    );

    // Output port register and input change detector
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        port_out_d = port_out_q;
        if (wr_en && reg_sel == IO_OUT) begin
            port_out_d = data_in;
        end
        prev_d  = port_sync;
        chg_set = (port_sync != prev_q);
    end

    // Timer next-state: a write always wins over expiry in the same cycle
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        count_d  = count_q;
        texp_set = 1'b0;
        if (wr_en && reg_sel == IO_TMR) begin
            reload_d = data_in;
            count_d  = data_in;
            state_d  = (data_in != '0) ? RUN : IDLE;
        end else begin
            case (state_q)
                RUN: begin
                    if (count_q == 16'd1) begin
                        count_d  = reload_q;
                        texp_set = 1'b1;
                    end else begin
                        count_d  = count_q - 16'd1;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Sticky status with write-one-to-clear; a same-cycle set beats the clear
    always_comb begin
        stat_set            = '0;
        stat_set[STAT_CHG]  = chg_set;
        stat_set[STAT_TEXP] = texp_set;
        stat_clr            = '0;
        if (wr_en && reg_sel == IO_STAT) begin
            stat_clr = data_in[STAT_W-1:0];
        end
        stat_d = stat_set | (stat_q & ~stat_clr);
        irq_d  = stat_q[STAT_CHG] | stat_q[STAT_TEXP];
    end

    // State registers; reset abandons any running count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_out_q <= '0;
            prev_q     <= '0;
            stat_q     <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            irq_q      <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            prev_q     <= prev_d;
            stat_q     <= stat_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            state_q    <= state_d;
            irq_q      <= irq_d;
        end
    end

    // Combinational read mux; zero when the access is not for IO space
    always_comb begin
        data_out = '0;
        if (iom_in) begin
            case (reg_sel)
                IO_OUT:  data_out = port_out_q;
                IO_IN:   data_out = port_sync;
                IO_STAT: data_out = {{(IO_DW-STAT_W){1'b0}}, stat_q};
                IO_TMR:  data_out = count_q;
                default: data_out = '0;
            endcase
        end
    end

    assign port_out = port_out_q;
    assign irq_out  = irq_q;

endmodule : io_unit
